// File: rtl/ula_op_controller.sv
// ula_op_controller: sequencer for the 4-bit ULA datapath.
// Accepts one operation at a time, registers operands, drives the result mux
// select, launches the multi-cycle multiplier/divider, and returns the
// captured result and flags on a valid/ready response port.
// Optional feature macro: ULA_CTRL_TIMEOUT_EN enables the WAIT-state timeout
// (error response after TIMEOUT wait cycles with no done).
//
// state | meaning
// IDLE  | ready for a request, latches operands/select on acceptance
// EXEC  | single-cycle op, capture mux_out (and carry for add/sub)
// START | one-cycle start pulse to multiplier or divider
// WAIT  | wait for matching done (optionally bounded by TIMEOUT)
// RESP  | response presented, held until rsp_ready
module ula_op_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic [3:0] opa,
  output logic [3:0] opb,
  output logic [2:0] mux_sel,
  input  logic [3:0] mux_out,
  input  logic       carry_in,
  output logic       mul_start,
  input  logic       mul_done,
  output logic       div_start,
  input  logic       div_done,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       rsp_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_INV = 3'b111;

`ifdef ULA_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // The counter holds k-1 during the k-th WAIT cycle, so the last allowed
  // WAIT cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [2:0] op;
  logic [7:0] wait_cnt;
  logic       req_err;
  logic       done;
  logic       timeout_hit;

  // Request error decode, matching-done select and timeout condition
  always_comb begin
    req_err     = (req_op == OP_INV) || ((req_op == OP_DIV) && (req_b == 4'd0));
    done        = (op == OP_MUL) ? mul_done : div_done;
    timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake/start outputs
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                  state_n = RESP;
          else if ((req_op == OP_MUL) || (req_op == OP_DIV)) state_n = START;
          else                                          state_n = EXEC;
        end
      end
      EXEC:  state_n = RESP;
      START: begin
        mul_start = (op == OP_MUL);
        div_start = (op == OP_DIV);
        state_n   = WAIT;
      end
      WAIT: begin
        if (done || timeout_hit) state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand/select latching, wait counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op         <= 3'd0;
      opa        <= 4'd0;
      opb        <= 4'd0;
      mux_sel    <= 3'd0;
      wait_cnt   <= 8'd0;
      rsp_result <= 4'd0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op      <= req_op;
            opa     <= req_a;
            opb     <= req_b;
            mux_sel <= req_op;
            if (req_err) begin
              rsp_result <= 4'd0;
              rsp_zero   <= 1'b0;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_result <= mux_out;
          rsp_zero   <= (mux_out == 4'd0);
          rsp_carry  <= ((op == OP_ADD) || (op == OP_SUB)) && carry_in;
          rsp_err    <= 1'b0;
        end
        START: wait_cnt <= 8'd0;
        WAIT: begin
          if (done) begin
            rsp_result <= mux_out;
            rsp_zero   <= (mux_out == 4'd0);
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              rsp_result <= 4'd0;
              rsp_zero   <= 1'b0;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_op_controller.sv
// Self-checking bench for ula_op_controller. A small datapath model drives
// mux_out/carry_in from the controller's select and operands; expected
// responses and latencies come from a transaction-level reference model.
module tb_ula_op_controller;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a, req_b;
  logic [3:0] opa, opb;
  logic [2:0] mux_sel;
  logic [3:0] mux_out;
  logic       carry_in;
  logic       mul_start, mul_done, div_start, div_done;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero, rsp_carry, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  ula_op_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .opa(opa), .opb(opb), .mux_sel(mux_sel),
    .mux_out(mux_out), .carry_in(carry_in),
    .mul_start(mul_start), .mul_done(mul_done),
    .div_start(div_start), .div_done(div_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each op: {carry, result}
  function automatic logic [4:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(a) + (15 - int'(b)) + 1;
      3'd2: r = int'(a | b);
      3'd3: r = int'(a & b);
      3'd4: r = int'(a ^ b);
      3'd5: r = (int'(a) * int'(b)) % 16;
      3'd6: r = (b == 4'd0) ? 0 : int'(a) / int'(b);
      default: r = 15;
    endcase
    return 5'(r);
  endfunction

  // Datapath model seen by the controller
  always_comb begin
    logic [4:0] v;
    v        = alu(mux_sel, opa, opb);
    mux_out  = v[3:0];
    carry_in = (mux_sel <= 3'd1) ? v[4] : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction. k: WAIT cycle in which done arrives (0 = never).
  task automatic do_txn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int k, input int hold);
    logic       rerr, multi, to, e_err, e_c, e_z;
    logic [4:0] ar;
    logic [3:0] e_res;
    int         e_lat, lat, n_mul, n_div, st_cyc;
    rerr  = (op == 3'd7) || (op == 3'd6 && b == 4'd0);
    multi = !rerr && (op == 3'd5 || op == 3'd6);
    to    = multi && (k == 0);
    ar    = alu(op, a, b);
    e_err = rerr || to;
    e_res = e_err ? 4'd0 : ar[3:0];
    e_c   = (!e_err && op <= 3'd1) ? ar[4] : 1'b0;
    e_z   = !e_err && (e_res == 4'd0);
    e_lat = rerr ? 1 : (multi ? (to ? 2 + TO : 2 + k) : 2);

    chk("req_ready_before", 8'(req_ready), 8'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
    chk("opa", 8'(opa), 8'(a));
    chk("opb", 8'(opb), 8'(b));
    chk("mux_sel", 8'(mux_sel), 8'(op));
    chk("req_ready_busy", 8'(req_ready), 8'd0);

    lat = 0; n_mul = 0; n_div = 0; st_cyc = 0;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      if (mul_start) begin n_mul++; st_cyc = cyc; end
      if (div_start) begin n_div++; st_cyc = cyc; end
      if (rsp_valid) lat = cyc;
      else begin
        // matching done: pulse in START (must be ignored) and in WAIT cycle k
        mul_done = (op == 3'd5) ? (multi && (cyc == 1 || (k > 0 && cyc == 1 + k)))
                                : 1'($urandom_range(0, 1));
        div_done = (op == 3'd6) ? (multi && (cyc == 1 || (k > 0 && cyc == 1 + k)))
                                : 1'($urandom_range(0, 1));
        tick();
      end
    end
    mul_done = 1'b0; div_done = 1'b0;

    chk("latency", 8'(lat), 8'(e_lat));
    chk("mul_start_count", 8'(n_mul), 8'((op == 3'd5) ? 1 : 0));
    chk("div_start_count", 8'(n_div), 8'(multi && op == 3'd6));
    if (multi) chk("start_cycle", 8'(st_cyc), 8'd1);
    chk("rsp_result", 8'(rsp_result), 8'(e_res));
    chk("rsp_zero", 8'(rsp_zero), 8'(e_z));
    chk("rsp_carry", 8'(rsp_carry), 8'(e_c));
    chk("rsp_err", 8'(rsp_err), 8'(e_err));

    for (int i = 0; i < hold; i++) begin
      mul_done = 1'($urandom_range(0, 1)); div_done = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", 8'(rsp_valid), 8'd1);
      chk("hold_ready", 8'(req_ready), 8'd0);
      chk("hold_resp", {rsp_result, rsp_zero, rsp_carry, rsp_err, 1'b0},
                       {e_res, e_z, e_c, e_err, 1'b0});
      chk("hold_ops", {opa, opb}, {a, b});
      chk("hold_sel", 8'(mux_sel), 8'(op));
    end
    mul_done = 1'b0; div_done = 1'b0;

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_hs_valid", 8'(rsp_valid), 8'd0);
    chk("post_hs_ready", 8'(req_ready), 8'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 4'd0; req_b = 4'd0;
    mul_done = 1'b0; div_done = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 8'(req_ready), 8'd1);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp", {rsp_result, rsp_zero, rsp_carry, rsp_err, 1'b0}, 8'd0);
    chk("rst_starts", {6'd0, mul_start, div_start}, 8'd0);
    chk("rst_ops", {opa, opb}, 8'd0);
    chk("rst_sel", 8'(mux_sel), 8'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_txn(3'd0, 4'd3, 4'd4, 0, 5);
    do_txn(3'd1, 4'd5, 4'd5, 0, 0);
    do_txn(3'd5, 4'd3, 4'd2, 3, 5);
    do_txn(3'd6, 4'd7, 4'd0, 0, 1);
    do_txn(3'd7, 4'd9, 4'd2, 0, 0);
    do_txn(3'd6, 4'd13, 4'd4, 1, 2);

`ifdef ULA_CTRL_TIMEOUT_EN
    do_txn(3'd6, 4'd9, 4'd3, 0, 5);
`else
    // Divider never finishes: controller must stay in WAIT
    req_valid = 1'b1; req_op = 3'd6; req_a = 4'd9; req_b = 4'd3;
    tick();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      mul_done = 1'($urandom_range(0, 1));
      tick();
      if (rsp_valid || req_ready) seen++;
    end
    mul_done = 1'b0;
    chk("wait_forever", 8'(seen), 8'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("recover_ready", 8'(req_ready), 8'd1);
`endif

    // Reset in the middle of a multiply's WAIT
    req_valid = 1'b1; req_op = 3'd5; req_a = 4'd3; req_b = 4'd2;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 8'(req_ready), 8'd1);
    chk("midrst_valid", 8'(rsp_valid), 8'd0);
    chk("midrst_sel", 8'(mux_sel), 8'd0);
    chk("midrst_starts", {6'd0, mul_start, div_start}, 8'd0);
    tick();
    rst = 1'b0;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || !req_ready) seen++;
      tick();
    end
    chk("late_done_ignored", 8'(seen), 8'd0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic [3:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      do_txn(op, a, b, $urandom_range(1, 10), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_op_controller.md
# ula_op_controller

Sequencer for the 4-bit ULA datapath. It accepts one operation request at a time over a valid/ready handshake and registers the operands for the functional units. It drives the 3-bit select of the eight-way result multiplexer, starts and waits on the multi-cycle multiplier and divider, captures the selected result with flags, and presents it on a valid/ready response port. It sits between the operator-facing input logic and the ULA datapath.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles for `mul_done`/`div_done`; legal range 1..255.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset; **synchronous, active-high**
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request
- `req_op`  in  3  op code: 000 add, 001 sub, 010 or, 011 and, 100 xor, 101 mul, 110 div, 111 invalid
- `req_a`, `req_b`  in  4  operands
- `opa`, `opb`  out  4  registered operands to the functional units
- `mux_sel`  out  3  select for the result multiplexer
- `mux_out`  in  4  selected result from the multiplexer
- `carry_in`  in  1  carry/borrow from the adder/subtractor
- `mul_start`  out  1  one-cycle start pulse to the multiplier
- `mul_done`  in  1  multiplier result valid
- `div_start`  out  1  one-cycle start pulse to the divider
- `div_done`  in  1  divider result valid
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_result`  out  4  captured result
- `rsp_zero`, `rsp_carry`, `rsp_err`  out  1  flags

## Operation
- **States:** IDLE, EXEC, START, WAIT, RESP.
- **IDLE**
  - `req_ready`=1. All other handshake outputs are 0.
  - On `req_valid`, latch `req_op`→op register, `req_a`→`opa`, `req_b`→`opb`, and `mux_sel`←`req_op`.
  - Next state:
    - op 111: RESP with error.
    - op 110 with `req_b`==0: RESP with error. No `div_start` is issued.
    - op 000–100: EXEC.
    - op 101/110 otherwise: START.
- **EXEC:** capture `mux_out`→`rsp_result`. For op 000/001 also capture `carry_in`→`rsp_carry`; for other ops `rsp_carry`=0. Then go to RESP.
- **START:** assert `mul_start` (op 101) or `div_start` (op 110) for exactly this one cycle. Clear the wait counter. Go to WAIT.
- **WAIT**
  - The matching done input is sampled only in this state.
  - On done: capture `mux_out`, set `rsp_carry`=0, go to RESP.
  - Otherwise increment the wait counter (8-bit).
- **RESP**
  - `rsp_valid`=1. `rsp_result` and all flags are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- **Error responses:** `rsp_err`=1, `rsp_result`=0000, `rsp_carry`=0, `rsp_zero`=0.
- **Zero flag:** `rsp_zero` = (`rsp_result`==0) && !`rsp_err`.
- **Operand and select hold:** `opa`, `opb` and `mux_sel` stay constant from acceptance until the response completes.
- **Ignored done pulses:** done pulses outside WAIT, and the non-matching done input during WAIT, are ignored.

## Timing
- **Reset values:** `req_ready`=1 (IDLE). `rsp_valid`, `rsp_result`, `rsp_zero`, `rsp_carry`, `rsp_err`, `mul_start`, `div_start` = 0. `mux_sel`, `opa`, `opb` = 0.
- **Reset mid-operation:** at the next edge the controller is in IDLE with the values above. The in-flight request is discarded and no response is produced.
- **Logic ops 000–100:** request accepted at edge T, capture at T+1, `rsp_valid` high in cycle T+2 at the earliest.
- **Error ops:** `rsp_valid` at T+1.
- **mul/div:** start pulse in cycle T+1. If done is seen in the k-th WAIT cycle (k≥1), `rsp_valid` rises at T+2+k.
- **One transaction at a time:** `req_ready`=0 from the acceptance edge until the response handshake completes. The earliest next acceptance is the cycle after the handshake.
- **Response-to-request turnaround:** `rsp_valid` drops one cycle after the handshake edge, and `req_ready` rises at the same time.

## Configuration
- **`ULA_CTRL_TIMEOUT_EN` defined**
  - In WAIT, if the wait counter reaches `TIMEOUT` without a done, go to RESP with an error response.
  - If done and the timeout condition occur in the same cycle, done wins.
- **`ULA_CTRL_TIMEOUT_EN` undefined:** WAIT lasts indefinitely until done or `rst`. The counter and the `TIMEOUT` parameter have no effect.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-WAIT of a mul.
  - Next cycle: `req_ready`=1, `rsp_valid`=0, `mux_sel`=000, no start pulses.
  - A later `mul_done` is ignored.
- **Add:** op=000, a=3, b=4, bench drives `mux_out`=0111 and `carry_in`=0.
  - `mux_sel`=000, `opa`=3, `opb`=4.
  - `rsp_valid` at T+2 with result=0111, zero=0, carry=0, err=0.
- **Subtract:** op=001, a=5, b=5, `mux_out`=0000, `carry_in`=1.
  - Response: result=0, zero=1, carry=1.
- **Multiply:** op=101, a=3, b=2, `mul_done` in the 3rd WAIT cycle with `mux_out`=0110.
  - Exactly one `mul_start` pulse, in cycle T+1.
  - `rsp_valid` at T+5 with result=0110, carry=0.
- **Errors:**
  - op=110, b=0: no `div_start`; response at T+1 with err=1, result=0, zero=0.
  - op=111: same response.
- **Timeout and backpressure**
  - With the macro and `TIMEOUT`=15: op=110, b=3, `div_done` never asserted. Error response after 15 WAIT cycles.
  - Without the macro: the controller is still in WAIT after 100 cycles.
  - In either case, hold `rsp_ready`=0 for 5 cycles while `rsp_valid`=1: all response outputs stay stable and `req_ready`=0.
